flash_checker: RTL and testbench
================================

Name: flash_checker

Overview:
- Receive-side companion to the LED flash generator. Monitors the generator's o_flash bus and decodes the active LED index.
- Verifies the walking one-hot sequence 0001→0010→0100→1000→0001 and declares lock after a run of consecutive correct steps.
- Flags sequence errors and stalls (watchdog) while locked, and keeps a saturating error count.
- Sits beside the flash generator in the introduction design, on the same clock and reset.

Parameters:
- NB_LED, 4, width of flash bus (power of two, ≥2).
- NB_IDX, 2, width of decoded index (log2 NB_LED).
- LOCK_COUNT, 4, consecutive valid steps required to enter LOCK (1..15).
- NB_TIMER, 8, watchdog counter width.
- TIMEOUT, 32, max cycles between steps while locked (< 2**NB_TIMER).
- NB_ERR, 8, error counter width.

Ports:
- clock  in  1  system clock, all logic posedge.
- i_reset  in  1  asynchronous, active-low reset (0 = reset).
- i_flash  in  NB_LED  flash pattern from generator.
- i_clear  in  1  synchronous clear of o_err_count (other state untouched).
- o_lock  out  1  1 while in LOCK.
- o_error  out  1  one-cycle pulse per detected error.
- o_index  out  NB_IDX  binary position of the lit LED (last valid one-hot).
- o_dir  out  1  0 = left/up, 1 = right/down.
- o_err_count  out  NB_ERR  saturating count of errors.
- o_state  out  2  00 SEARCH, 01 LOCK, 10 ERROR.

Behaviour:
- Reset (i_reset=0, async): r_flash=0, r_prev=0, good count=0, timer=0, state SEARCH. Outputs: o_lock=0, o_error=0, o_index=0, o_dir=0, o_err_count=0, o_state=00.
- Input path:
  - Edge N: i_flash registered into r_flash.
  - Edge N+1: r_flash compared with r_prev; r_prev<=r_flash.
  - A "change" means r_flash != r_prev.
  - A "valid step" is a change where both values are one-hot and r_flash == rotate_left(r_prev), with wrap from MSB to LSB.
- o_index updates at the compare edge whenever r_flash is one-hot; otherwise it holds.
- SEARCH:
  - Valid step: good count++.
  - Any other change: good count<=0.
  - Valid step making good count == LOCK_COUNT: state->LOCK, good count<=0, timer<=0.
  - Therefore o_lock rises two edges after the edge that samples the LOCK_COUNT-th stepped pattern.
  - No error reporting in SEARCH.
- LOCK:
  - Timer increments each cycle without a change and resets to 0 on a valid step.
  - Invalid change (non-one-hot, wrong direction, skip) -> ERROR.
  - Timer reaching TIMEOUT -> ERROR.
  - Both conditions in the same cycle count as one error.
- ERROR (exactly one cycle):
  - o_error=1, o_err_count++ (saturates at all-ones), o_lock=0.
  - Next state SEARCH, good count=0, timer=0.
- i_clear:
  - o_err_count<=0 next edge.
  - If i_clear coincides with an error increment, clear wins (count=0).
- Reset mid-operation: immediate return to reset values regardless of state.
- Constant i_flash (including 0000) in SEARCH: no change, no counting, no error.

Optional Feature:
- FLASH_CHECKER_BIDIR_EN defined:
  - rotate_right(r_prev) is also a valid step; the first valid step in SEARCH sets o_dir.
  - In LOCK, a direction reversal is valid only at the ends (index 0 or NB_LED-1), for ping-pong patterns. Reversal elsewhere is an error.
  - o_dir tracks the current direction.
- Not defined: only rotate_left is valid; o_dir is tied to 0.

Decomposition:
- Shared package flash_pkg holds:
  - state encoding constants (ST_SEARCH=2'b00, ST_LOCK=2'b01, ST_ERROR=2'b10);
  - NB_LED default;
  - rotate and one-hot-check functions (shared with the generator).
- One sub-module, flash_onehot_dec: combinational one-hot detect plus binary encode (NB_LED -> valid, index).

Test Plan:
- Reset, then drive i_flash 0001,0010,0100,1000,0001 with a step every 8 cycles -> o_lock=1 two edges after the 4th step is sampled; o_index=0 after the final step; o_err_count=0.
- Locked, then inject 0101 -> o_error pulses 1 cycle, o_err_count=1, o_state 01->10->00, o_lock=0; re-lock after 4 valid steps.
- Locked, hold i_flash constant for 40 cycles -> o_error once TIMEOUT=32 is reached, o_err_count increments by 1.
- Force 256 errors with NB_ERR=8 -> o_err_count saturates at 255; i_clear asserted together with an error -> count=0.
- Deassert i_reset mid-LOCK -> all outputs 0 immediately (async); after release the checker needs 4 fresh steps to lock.
- With FLASH_CHECKER_BIDIR_EN: ping-pong 0001..1000,0100..0001 -> stays locked, o_dir toggles at the ends; reversal at 0100 mid-run -> o_error.

Source files
------------

// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared state encoding and one-hot/rotate helpers for the flash generator and checker
package flash_pkg;

    localparam int FLASH_NB_LED = 4;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'b00,
        ST_LOCK   = 2'b01,
        ST_ERROR  = 2'b10
    } flash_state_e;

    // Helpers work on a 32-bit container; n is the live width of the flash bus.
    function automatic logic [31:0] width_mask(input int unsigned n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
        logic [31:0] m;
        m = width_mask(n);
        return (((v & m) << 1) | ((v & m) >> (n - 1))) & m;
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] v, input int unsigned n);
        logic [31:0] m;
        m = width_mask(n);
        return (((v & m) >> 1) | ((v & m) << (n - 1))) & m;
    endfunction

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/flash_onehot_dec.sv
// rtl/flash_onehot_dec.sv - combinational one-hot detect and binary encode of the flash bus
module flash_onehot_dec
    import flash_pkg::*;
#(
    parameter int NB_LED = 4,
    parameter int NB_IDX = 2
) (
    input  logic [NB_LED-1:0] i_vec,
    output logic              o_valid,
    output logic [NB_IDX-1:0] o_index
);

    // OR-ing the positions of set bits is exact whenever the input is one-hot.
    always_comb begin
        o_valid = is_onehot(32'(i_vec));
        o_index = '0;
        for (int i = 0; i < NB_LED; i++) begin
            if (i_vec[i]) begin
                o_index = o_index | NB_IDX'(i);
            end
        end
    end

endmodule

// File: rtl/flash_checker.sv
// rtl/flash_checker.sv - walking one-hot sequence checker with lock, watchdog and error count
// Optional: FLASH_CHECKER_BIDIR_EN accepts right rotation and ping-pong reversal at the ends.
module flash_checker
    import flash_pkg::*;
#(
    parameter int NB_LED     = FLASH_NB_LED,
    parameter int NB_IDX     = 2,
    parameter int LOCK_COUNT = 4,
    parameter int NB_TIMER   = 8,
    parameter int TIMEOUT    = 32,
    parameter int NB_ERR     = 8
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_LED-1:0] i_flash,
    input  logic              i_clear,
    output logic              o_lock,
    output logic              o_error,
    output logic [NB_IDX-1:0] o_index,
    output logic              o_dir,
    output logic [NB_ERR-1:0] o_err_count,
    output logic [1:0]        o_state
);

    localparam logic [3:0]          LOCK_V    = 4'(LOCK_COUNT);
    localparam logic [NB_TIMER-1:0] TIMEOUT_V = NB_TIMER'(TIMEOUT);
    localparam logic [NB_IDX-1:0]   IDX_MAX   = NB_IDX'(NB_LED - 1);

    logic [NB_LED-1:0]   r_flash_q, r_prev_q, rot_l;
    logic                flash_oh, prev_oh;
    logic [NB_IDX-1:0]   flash_idx, prev_idx, index_q;
    logic                chg_c, step_l_c, step_r_c, at_end_c;
    logic                chg_q, step_l_q, step_r_q, at_end_q;
    flash_state_e        state_q, state_d;
    logic [3:0]          good_q, good_d;
    logic [NB_TIMER-1:0] timer_q, timer_d, timer_inc;
    logic                dir_q, dir_d;
    logic [NB_ERR-1:0]   err_q, err_d;
    logic                step_any, new_dir, step_ok, err_hit;

    flash_onehot_dec #(.NB_LED(NB_LED), .NB_IDX(NB_IDX)) u_dec_flash (
        .i_vec   (r_flash_q),
        .o_valid (flash_oh),
        .o_index (flash_idx)
    );

    flash_onehot_dec #(.NB_LED(NB_LED), .NB_IDX(NB_IDX)) u_dec_prev (
        .i_vec   (r_prev_q),
        .o_valid (prev_oh),
        .o_index (prev_idx)
    );

    assign rot_l    = NB_LED'(rotl(32'(r_prev_q), NB_LED));
    assign chg_c    = (r_flash_q != r_prev_q);
    assign step_l_c = chg_c && flash_oh && prev_oh && (r_flash_q == rot_l);
    assign at_end_c = (prev_idx == '0) || (prev_idx == IDX_MAX);

`ifdef FLASH_CHECKER_BIDIR_EN
    logic [NB_LED-1:0] rot_r;
    assign rot_r    = NB_LED'(rotr(32'(r_prev_q), NB_LED));
    assign step_r_c = chg_c && flash_oh && prev_oh && (r_flash_q == rot_r);
`else
    assign step_r_c = 1'b0;
`endif

    // Compare results are registered so the FSM acts one edge after the compare edge.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_flash_q <= '0;
            r_prev_q  <= '0;
            chg_q     <= 1'b0;
            step_l_q  <= 1'b0;
            step_r_q  <= 1'b0;
            at_end_q  <= 1'b0;
            index_q   <= '0;
            state_q   <= ST_SEARCH;
            good_q    <= '0;
            timer_q   <= '0;
            dir_q     <= 1'b0;
            err_q     <= '0;
        end else begin
            r_flash_q <= i_flash;
            r_prev_q  <= r_flash_q;
            chg_q     <= chg_c;
            step_l_q  <= step_l_c;
            step_r_q  <= step_r_c;
            at_end_q  <= at_end_c;
            if (flash_oh) begin
                index_q <= flash_idx;
            end
            state_q   <= state_d;
            good_q    <= good_d;
            timer_q   <= timer_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        timer_d   = timer_q;
        dir_d     = dir_q;
        err_d     = err_q;
        err_hit   = 1'b0;
        timer_inc = timer_q + 1'b1;
        step_any  = step_l_q | step_r_q;
        // With NB_LED=2 both rotations coincide, so direction is ambiguous and kept.
        new_dir   = (step_l_q && step_r_q) ? dir_q : step_r_q;
        step_ok   = step_any && ((new_dir == dir_q) || at_end_q);

        unique case (state_q)
            ST_SEARCH: begin
                if (chg_q) begin
                    if (step_any) begin
                        dir_d = new_dir;
                        if (good_q + 4'd1 == LOCK_V) begin
                            state_d = ST_LOCK;
                            good_d  = '0;
                            timer_d = '0;
                        end else begin
                            good_d = good_q + 4'd1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
            end
            ST_LOCK: begin
                if (chg_q && step_ok) begin
                    timer_d = '0;
                    dir_d   = new_dir;
                end else if (chg_q || (timer_inc >= TIMEOUT_V)) begin
                    err_hit = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = '0;
                timer_d = '0;
            end
        endcase

        if (err_hit) begin
            state_d = ST_ERROR;
            good_d  = '0;
            timer_d = '0;
        end

        if (i_clear) begin
            err_d = '0;
        end else if (err_hit && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
    end

    assign o_lock      = (state_q == ST_LOCK);
    assign o_error     = (state_q == ST_ERROR);
    assign o_index     = index_q;
    assign o_dir       = dir_q;
    assign o_err_count = err_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_flash_checker.sv
// tb/tb_flash_checker.sv - scoreboard bench for flash_checker (FLASH_CHECKER_BIDIR_EN selects ping-pong test)
module tb_flash_checker;

    logic       clock = 1'b0;
    logic       i_reset;
    logic [3:0] i_flash;
    logic       i_clear;
    logic       o_lock, o_error, o_dir;
    logic [1:0] o_index, o_state;
    logic [7:0] o_err_count;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_cnt  = 8'd0;
    logic [7:0] err_sb[$];
    logic [7:0] sb_exp;

    flash_checker dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_flash     (i_flash),
        .i_clear     (i_clear),
        .o_lock      (o_lock),
        .o_error     (o_error),
        .o_index     (o_index),
        .o_dir       (o_dir),
        .o_err_count (o_err_count),
        .o_state     (o_state)
    );

    always #5 clock = ~clock;

    // Every o_error pulse must match an expected error pushed by the stimulus.
    always @(negedge clock) begin
        if (i_reset && o_error) begin
            n_checks++;
            if (err_sb.size() == 0) begin
                $display("FAIL unexpected_error: o_error=1 count=%0d, required no error", o_err_count);
            end else begin
                sb_exp = err_sb.pop_front();
                if (o_err_count !== sb_exp || o_lock !== 1'b0 || o_state !== 2'b10)
                    $display("FAIL error_event: count=%0d lock=%b state=%b, required count=%0d lock=0 state=10",
                             o_err_count, o_lock, o_state, sb_exp);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive(input logic [3:0] p, input int n);
        i_flash = p;
        tick(n);
    endtask

    task automatic expect_error();
        exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
        err_sb.push_back(exp_cnt);
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_flash = 4'b0000;
        i_clear = 1'b0;
        tick(3);
        n_checks++;
        if ({o_lock, o_error, o_index, o_dir, o_err_count, o_state} !== 14'd0)
            $display("FAIL reset_outputs: lock=%b err=%b idx=%0d dir=%b cnt=%0d st=%b, required all 0",
                     o_lock, o_error, o_index, o_dir, o_err_count, o_state);
        else n_pass++;
        i_reset = 1'b1;
        drive(4'b0000, 6);
        n_checks++;
        if (o_state !== 2'b00) $display("FAIL const_zero_search: state=%b, required 00", o_state);
        else n_pass++;
    endtask

    task automatic test_lock();
        drive(4'b0001, 8);
        drive(4'b0010, 8);
        drive(4'b0100, 8);
        drive(4'b1000, 8);
        n_checks++;
        if (o_lock !== 1'b0 || o_index !== 2'd3)
            $display("FAIL pre_lock: lock=%b idx=%0d, required lock=0 idx=3", o_lock, o_index);
        else n_pass++;
        i_flash = 4'b0001;
        tick(1);
        n_checks++;
        if (o_lock !== 1'b0) $display("FAIL lock_latency_1: lock=%b, required 0", o_lock);
        else n_pass++;
        tick(1);
        n_checks++;
        if (o_lock !== 1'b0) $display("FAIL lock_latency_2: lock=%b, required 0", o_lock);
        else n_pass++;
        tick(1);
        n_checks++;
        if (o_lock !== 1'b1) $display("FAIL lock_latency_3: lock=%b, required 1", o_lock);
        else n_pass++;
        tick(5);
        n_checks++;
        if (o_index !== 2'd0 || o_err_count !== 8'd0 || o_state !== 2'b01)
            $display("FAIL locked_state: idx=%0d cnt=%0d st=%b, required idx=0 cnt=0 st=01",
                     o_index, o_err_count, o_state);
        else n_pass++;
    endtask

    task automatic test_error_inject();
        expect_error();
        i_flash = 4'b0101;
        tick(2);
        n_checks++;
        if (o_state !== 2'b01) $display("FAIL inject_st_lock: st=%b, required 01", o_state);
        else n_pass++;
        tick(1);
        n_checks++;
        if (o_state !== 2'b10 || o_error !== 1'b1) $display("FAIL inject_st_err: st=%b err=%b, required 10/1", o_state, o_error);
        else n_pass++;
        tick(1);
        n_checks++;
        if (o_state !== 2'b00 || o_error !== 1'b0 || o_lock !== 1'b0)
            $display("FAIL inject_st_search: st=%b err=%b lock=%b, required 00/0/0", o_state, o_error, o_lock);
        else n_pass++;
        drive(4'b0001, 8);
        drive(4'b0010, 8);
        drive(4'b0100, 8);
        drive(4'b1000, 8);
        drive(4'b0001, 8);
        n_checks++;
        if (o_lock !== 1'b1 || o_err_count !== 8'd1 || err_sb.size() != 0)
            $display("FAIL relock: lock=%b cnt=%0d pending=%0d, required lock=1 cnt=1 pending=0",
                     o_lock, o_err_count, err_sb.size());
        else n_pass++;
    endtask

    task automatic test_timeout();
        expect_error();
        drive(4'b0001, 40);
        n_checks++;
        if (err_sb.size() != 0 || o_err_count !== exp_cnt || o_state !== 2'b00)
            $display("FAIL timeout: pending=%0d cnt=%0d st=%b, required pending=0 cnt=%0d st=00",
                     err_sb.size(), o_err_count, o_state, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int it = 0; it < 256; it++) begin
            drive(4'b0001, 1);
            drive(4'b0010, 1);
            drive(4'b0100, 1);
            drive(4'b1000, 1);
            drive(4'b0001, 1);
            expect_error();
            drive(4'b0101, 1);
        end
        tick(4);
        n_checks++;
        if (o_err_count !== 8'hFF || err_sb.size() != 0)
            $display("FAIL saturate: cnt=%0d pending=%0d, required cnt=255 pending=0", o_err_count, err_sb.size());
        else n_pass++;
        drive(4'b0001, 1);
        drive(4'b0010, 1);
        drive(4'b0100, 1);
        drive(4'b1000, 1);
        drive(4'b0001, 1);
        err_sb.push_back(8'd0);
        exp_cnt = 8'd0;
        drive(4'b0101, 2);
        i_clear = 1'b1;
        tick(1);
        i_clear = 1'b0;
        tick(4);
        n_checks++;
        if (o_err_count !== 8'd0 || err_sb.size() != 0)
            $display("FAIL clear_wins: cnt=%0d pending=%0d, required cnt=0 pending=0", o_err_count, err_sb.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(4'b0001, 4);
        drive(4'b0010, 4);
        drive(4'b0100, 4);
        drive(4'b1000, 4);
        drive(4'b0001, 4);
        n_checks++;
        if (o_lock !== 1'b1) $display("FAIL pre_reset_lock: lock=%b, required 1", o_lock);
        else n_pass++;
        #2 i_reset = 1'b0;
        #1;
        n_checks++;
        if ({o_lock, o_error, o_index, o_dir, o_err_count, o_state} !== 14'd0)
            $display("FAIL async_reset: lock=%b err=%b idx=%0d dir=%b cnt=%0d st=%b, required all 0",
                     o_lock, o_error, o_index, o_dir, o_err_count, o_state);
        else n_pass++;
        exp_cnt = 8'd0;
        tick(2);
        i_reset = 1'b1;
        drive(4'b0001, 4);
        drive(4'b0010, 4);
        drive(4'b0100, 4);
        drive(4'b1000, 4);
        n_checks++;
        if (o_lock !== 1'b0) $display("FAIL fresh_three_steps: lock=%b, required 0", o_lock);
        else n_pass++;
        drive(4'b0001, 4);
        n_checks++;
        if (o_lock !== 1'b1) $display("FAIL fresh_four_steps: lock=%b, required 1", o_lock);
        else n_pass++;
    endtask

    task automatic test_direction();
`ifdef FLASH_CHECKER_BIDIR_EN
        drive(4'b0010, 4);
        drive(4'b0100, 4);
        drive(4'b1000, 4);
        drive(4'b0100, 4);
        n_checks++;
        if (o_dir !== 1'b1 || o_lock !== 1'b1) $display("FAIL pingpong_top: dir=%b lock=%b, required 1/1", o_dir, o_lock);
        else n_pass++;
        drive(4'b0010, 4);
        drive(4'b0001, 4);
        drive(4'b0010, 4);
        n_checks++;
        if (o_dir !== 1'b0 || o_lock !== 1'b1) $display("FAIL pingpong_bottom: dir=%b lock=%b, required 0/1", o_dir, o_lock);
        else n_pass++;
        drive(4'b0100, 4);
        expect_error();
        drive(4'b0010, 6);
`else
        expect_error();
        drive(4'b1000, 6);
`endif
        n_checks++;
        if (err_sb.size() != 0 || o_lock !== 1'b0 || o_err_count !== exp_cnt)
            $display("FAIL bad_direction: pending=%0d lock=%b cnt=%0d, required pending=0 lock=0 cnt=%0d",
                     err_sb.size(), o_lock, o_err_count, exp_cnt);
        else n_pass++;
`ifndef FLASH_CHECKER_BIDIR_EN
        n_checks++;
        if (o_dir !== 1'b0) $display("FAIL dir_tied: dir=%b, required 0", o_dir);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_lock();
        test_error_inject();
        test_timeout();
        test_saturation();
        test_reset_mid();
        test_direction();
        tick(4);
        n_checks++;
        if (err_sb.size() != 0) $display("FAIL missed_errors: pending=%0d, required 0", err_sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
